sseg_scan_driver: RTL and testbench
===================================

# sseg_scan_driver

Time-multiplexed driver for a DIGITS-wide common-anode seven-segment display. It replaces per-digit static nibble decoding with one shared decoder that scans the digits at a programmable refresh rate. A tear-free shadow/display register pair lets the measurement path (sensor distance, pot value) update the value at any time. It sits between the theremin's value-formatting logic and the board's seg/an pins.

## Interface
- DIGITS, 4: number of digits scanned; legal 1..8.
- REFRESH_DIV, 50000: clk cycles each digit stays active; legal ≥2.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- value_in  in  4*DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i, digit 0 rightmost.
- dp_in  in  DIGITS  decimal-point request per digit, 1 = lit.
- load  in  1  one-cycle strobe; captures value_in/dp_in into the shadow register.
- blank  in  1  level; 1 forces all anodes off.
- seg  out  7  segments a..g, seg[6]=a, seg[0]=g, active-low.
- dp  out  1  decimal point, active-low.
- an  out  DIGITS  anode enables, active-low, an[i] = digit i.
- frame_done  out  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to 0.

## Operation
- Prescaler cnt, width $clog2(REFRESH_DIV): increments every cycle, wraps REFRESH_DIV-1 → 0. Terminal count = tick.
- Digit index idx: advances on tick; DIGITS-1 → 0 on wrap, and that wrap sets frame_done for that one cycle. DIGITS=1: idx constant 0, frame_done every tick.
- load high: shadow ← {value_in, dp_in}; pending ← 1. Back-to-back loads overwrite; the last one wins.
- On a wrap tick with pending set: display ← shadow, pending ← 0. If load and the wrap tick share a cycle, display ← value_in/dp_in directly and pending stays 0.
- Decode (nibble → seg, active-low abcdefg): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
- Registered outputs: an = ~(1<<idx), seg = decode(display nibble idx), dp = ~display dp bit idx. While blank=1: an all ones, seg 1111111, dp 1. Scan and load still run.
- Reset: cnt, idx, pending, shadow, display all 0. seg=1111111, dp=1, an all ones, frame_done=0.

## Timing
- Output latency: 1 cycle from idx or display change to pins.
- First edge after rst_n rises: an=…1110, seg=0000001, dp=1.
- Digit dwell: exactly REFRESH_DIV cycles. Frame: DIGITS*REFRESH_DIV cycles.
- load-to-display: at most one frame plus 1 cycle. Display never changes mid-frame.
- blank acts on pins 1 cycle after it changes.
- rst_n asserted mid-frame: all state and outputs go to reset values immediately. Pending load is discarded.

## Configuration
- SSEG_LZ_BLANK_EN defined: digit i>0 is blanked (an[i] stays high, seg=1111111) when display nibbles i..DIGITS-1 are all zero and dp bit i is 0. Digit 0 is never blanked. Dwell timing is unchanged; the slot is simply dark.
- Undefined: every digit is always displayed, including leading zeros.

## Structure
- Package sseg_pkg holds:
  - SEG_OFF = 7'b1111111;
  - the 16-entry segment constant table;
  - a helper function for counter width.
- Sub-module sseg_hex_decoder: combinational 4-bit → 7-bit active-low decoder using the table. Instantiated once, fed by the idx-selected display nibble.

## Test plan
All scenarios use DIGITS=4, REFRESH_DIV=4.
- Reset release, no load → an cycles 1110, 1101, 1011, 0111 every 4 cycles with seg=0000001; frame_done pulses every 16 cycles.
- load value_in=16'h12AF, dp_in=4'b0100 mid-frame → display unchanged until the next wrap. The next frame shows F=0111000, A=0001000, 2=0010010, 1=1001111, with dp=0 only on digit 2.
- load coincident with the wrap tick → the new value appears on digit 0 in the very next cycle's outputs. Two loads in one frame → only the second is shown.
- blank=1 for 10 cycles → an=1111, seg=1111111. Scan position afterwards matches an unblanked run.
- rst_n pulsed low during digit 2 → outputs all-off asynchronously; on release the scan restarts at digit 0 with display=0.
- SSEG_LZ_BLANK_EN defined, load 16'h0050 → digits 3 and 2 dark; digits 1 and 0 show 5 and 0. Undefined → all four digits lit.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scan driver: blank pattern,
// hex-to-segment table (active-low, seg[6]=a .. seg[0]=g) and a width helper.
package sseg_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

  // Counter width for a modulus n; never below one bit so n=1 still gets a register.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/sseg_hex_decoder.sv
// Combinational 4-bit hex nibble to active-low abcdefg segment pattern.
module sseg_hex_decoder
  import sseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_c
);

  // Table lookup; every nibble value has an entry.
  always_comb begin
    seg_c = SEG_TABLE[nibble];
  end

endmodule

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with a shadow/display
// register pair so values can be loaded at any time without tearing.
// Optional feature macro: SSEG_LZ_BLANK_EN (leading-zero blanking).
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  blank,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int unsigned CNT_W = cnt_width(REFRESH_DIV);
  localparam int unsigned IDX_W = cnt_width(DIGITS);
  localparam int unsigned VAL_W = 4 * DIGITS;

  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic              pending;
  logic [VAL_W-1:0]  shadow_val;
  logic [DIGITS-1:0] shadow_dp;
  logic [VAL_W-1:0]  display_val;
  logic [DIGITS-1:0] display_dp;

  logic              tick_c;
  logic              wrap_c;
  logic [3:0]        sel_nibble_c;
  logic              sel_dp_c;
  logic [DIGITS-1:0] an_sel_c;
  logic [6:0]        dec_seg_c;
  logic              lz_dark_c;
  logic [6:0]        seg_next_c;
  logic              dp_next_c;
  logic [DIGITS-1:0] an_next_c;

  // Prescaler terminal count and end-of-frame detection.
  always_comb begin
    tick_c = (cnt == CNT_W'(REFRESH_DIV - 1));
    wrap_c = tick_c && (idx == IDX_W'(DIGITS - 1));
  end

  // Select the active digit's nibble, dp bit and anode.
  always_comb begin
    sel_nibble_c = 4'h0;
    sel_dp_c     = 1'b0;
    an_sel_c     = '1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx == IDX_W'(i)) begin
        sel_nibble_c = display_val[4*i +: 4];
        sel_dp_c     = display_dp[i];
        an_sel_c[i]  = 1'b0;
      end
    end
  end

  sseg_hex_decoder u_dec (
    .nibble (sel_nibble_c),
    .seg_c  (dec_seg_c)
  );

`ifdef SSEG_LZ_BLANK_EN
  // Darken digit idx>0 when it and every digit above it are zero with no dp.
  always_comb begin
    logic zero_run;
    lz_dark_c = 1'b0;
    zero_run  = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      zero_run = zero_run && (display_val[4*i +: 4] == 4'h0);
      if ((idx == IDX_W'(i)) && zero_run && !display_dp[i]) begin
        lz_dark_c = 1'b1;
      end
    end
  end
`else
  assign lz_dark_c = 1'b0;
`endif

  // Pin values for the next cycle; blank and dark slots turn everything off.
  always_comb begin
    an_next_c  = '1;
    seg_next_c = SEG_OFF;
    dp_next_c  = 1'b1;
    if (!blank && !lz_dark_c) begin
      an_next_c  = an_sel_c;
      seg_next_c = dec_seg_c;
      dp_next_c  = ~sel_dp_c;
    end
  end

  // Scan counters, shadow/display transfer and registered pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      idx         <= '0;
      pending     <= 1'b0;
      shadow_val  <= '0;
      shadow_dp   <= '0;
      display_val <= '0;
      display_dp  <= '0;
      seg         <= SEG_OFF;
      dp          <= 1'b1;
      an          <= '1;
      frame_done  <= 1'b0;
    end else begin
      cnt <= tick_c ? '0 : cnt + CNT_W'(1);
      if (tick_c) begin
        idx <= wrap_c ? '0 : idx + IDX_W'(1);
      end
      frame_done <= wrap_c;

      if (load) begin
        shadow_val <= value_in;
        shadow_dp  <= dp_in;
      end

      // A load landing on the wrap tick bypasses the shadow entirely.
      if (wrap_c && load) begin
        display_val <= value_in;
        display_dp  <= dp_in;
        pending     <= 1'b0;
      end else if (wrap_c && pending) begin
        display_val <= shadow_val;
        display_dp  <= shadow_dp;
        pending     <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end

      seg <= seg_next_c;
      dp  <= dp_next_c;
      an  <= an_next_c;
    end
  end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Self-checking bench for sseg_scan_driver (DIGITS=4, REFRESH_DIV=4).
// A behavioural reference pushes expected pins per clock edge into a queue;
// each test pops and compares them, plus spot checks against fixed constants.
module tb_sseg_scan_driver;

  localparam int DIG  = 4;
  localparam int RDIV = 4;

  logic        clk;
  logic        rst_n;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // reference state
  int          m_cnt;
  int          m_idx;
  logic        m_pend;
  logic [15:0] m_sh_v;
  logic [3:0]  m_sh_dp;
  logic [15:0] m_disp_v;
  logic [3:0]  m_disp_dp;

  logic [6:0] seg_ref [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  sseg_scan_driver #(.DIGITS(DIG), .REFRESH_DIV(RDIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value_in   (value_in),
    .dp_in      (dp_in),
    .load       (load),
    .blank      (blank),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_cnt = 0; m_idx = 0; m_pend = 1'b0;
    m_sh_v = '0; m_sh_dp = '0; m_disp_v = '0; m_disp_dp = '0;
  endtask

  // Expected pins after the coming edge, then advance the reference state.
  task automatic model_edge(output exp_t e);
    logic [3:0] nib;
    logic [3:0] onehot;
    logic       dpb;
    logic       dark;
    logic       tick;
    logic       wrap;
    nib    = m_disp_v[4*m_idx +: 4];
    dpb    = m_disp_dp[m_idx];
    onehot = 4'b0001 << m_idx;
    dark   = 1'b0;
`ifdef SSEG_LZ_BLANK_EN
    if (m_idx > 0 && (m_disp_v >> (4*m_idx)) == 16'h0 && !dpb) dark = 1'b1;
`endif
    if (blank || dark) begin
      e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
    end else begin
      e.an = ~onehot; e.seg = seg_ref[nib]; e.dp = ~dpb;
    end
    tick = (m_cnt == RDIV - 1);
    wrap = tick && (m_idx == DIG - 1);
    e.fd = wrap;
    if (load) begin
      m_sh_v = value_in; m_sh_dp = dp_in;
    end
    if (wrap && load) begin
      m_disp_v = value_in; m_disp_dp = dp_in; m_pend = 1'b0;
    end else if (wrap && m_pend) begin
      m_disp_v = m_sh_v; m_disp_dp = m_sh_dp; m_pend = 1'b0;
    end else if (load) begin
      m_pend = 1'b1;
    end
    m_cnt = tick ? 0 : m_cnt + 1;
    if (tick) m_idx = wrap ? 0 : m_idx + 1;
  endtask

  // Push the expectation, cross one edge, pop it for the caller to compare.
  task automatic step(output exp_t e);
    exp_t t;
    model_edge(t);
    sb.push_back(t);
    @(posedge clk);
    #1;
    e = sb.pop_front();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b0; blank = 1'b0; value_in = '0; dp_in = '0;
    model_reset();
    #12;
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state an=%b seg=%b dp=%b fd=%b want an=1111 seg=1111111 dp=1 fd=0",
               an, seg, dp, frame_done);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_scan_idle();
    exp_t e;
    int   fd_cnt = 0;
    int   fd_first = -1;
    int   fd_last = -1;
    for (int s = 1; s <= 32; s++) begin
      step(e);
      checks++;
      if (an !== e.an || seg !== e.seg || dp !== e.dp || frame_done !== e.fd) begin
        errors++;
        $display("FAIL scan_idle step %0d got %b/%b/%b/%b want %b/%b/%b/%b",
                 s, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
      end
      if (s == 1) begin
        checks++;
        if (an !== 4'b1110 || seg !== 7'b0000001 || dp !== 1'b1) begin
          errors++;
          $display("FAIL first_edge an=%b seg=%b dp=%b want 1110/0000001/1", an, seg, dp);
        end
      end
      if (frame_done === 1'b1) begin
        fd_cnt++;
        if (fd_first < 0) fd_first = s;
        fd_last = s;
      end
    end
    checks++;
    if (fd_cnt != 2 || fd_last - fd_first != 16) begin
      errors++;
      $display("FAIL frame_period pulses=%0d gap=%0d want 2 and 16", fd_cnt, fd_last - fd_first);
    end
  endtask

  task automatic test_load_midframe();
    exp_t       e;
    logic [6:0] rec_seg [4];
    logic       rec_dp [4];
    int         guard = 0;
    for (int s = 0; s < 6; s++) step(e);
    value_in = 16'h12AF; dp_in = 4'b0100; load = 1'b1;
    step(e);
    load = 1'b0;
    // until the wrap edge the old (all-zero) value must remain on the pins
    while (!(m_idx == 0 && m_cnt == 0) && guard < 40) begin
      step(e);
      guard++;
      checks++;
      if (an !== e.an || seg !== e.seg || (an !== 4'hF && seg !== 7'b0000001)) begin
        errors++;
        $display("FAIL load_hold an=%b seg=%b want an=%b seg=0000001", an, seg, e.an);
      end
    end
    for (int i = 0; i < 4; i++) begin rec_seg[i] = 7'h7F; rec_dp[i] = 1'b1; end
    for (int s = 0; s < 16; s++) begin
      step(e);
      checks++;
      if (an !== e.an || seg !== e.seg || dp !== e.dp || frame_done !== e.fd) begin
        errors++;
        $display("FAIL load_frame got %b/%b/%b want %b/%b/%b", an, seg, dp, e.an, e.seg, e.dp);
      end
      for (int i = 0; i < 4; i++)
        if (an == ~(4'b0001 << i)) begin rec_seg[i] = seg; rec_dp[i] = dp; end
    end
    checks++;
    if (rec_seg[0] !== 7'b0111000 || rec_seg[1] !== 7'b0001000 ||
        rec_seg[2] !== 7'b0010010 || rec_seg[3] !== 7'b1001111) begin
      errors++;
      $display("FAIL load_digits got %b %b %b %b want 0111000 0001000 0010010 1001111",
               rec_seg[0], rec_seg[1], rec_seg[2], rec_seg[3]);
    end
    checks++;
    if (rec_dp[0] !== 1'b1 || rec_dp[1] !== 1'b1 || rec_dp[2] !== 1'b0 || rec_dp[3] !== 1'b1) begin
      errors++;
      $display("FAIL load_dp got %b%b%b%b want 1011 (d3..d0)", rec_dp[3], rec_dp[2], rec_dp[1], rec_dp[0]);
    end
  endtask

  task automatic test_load_wrap();
    exp_t       e;
    int         guard = 0;
    logic [6:0] d0_seg = 7'h7F;
    logic       d0_dp = 1'b1;
    while (!(m_idx == DIG - 1 && m_cnt == RDIV - 1) && guard < 32) begin
      step(e);
      guard++;
    end
    checks++;
    if (guard >= 32) begin
      errors++;
      $display("FAIL wrap_align no wrap tick within 32 cycles");
    end
    value_in = 16'h3456; dp_in = 4'b0000; load = 1'b1;
    step(e);
    load = 1'b0;
    step(e);
    checks++;
    if (an !== 4'b1110 || seg !== 7'b0100000 || an !== e.an || seg !== e.seg) begin
      errors++;
      $display("FAIL load_at_wrap an=%b seg=%b want 1110/0100000", an, seg);
    end
    // two loads inside one frame: only the later one may reach the pins
    step(e);
    value_in = 16'h1111; dp_in = 4'b0000; load = 1'b1;
    step(e);
    load = 1'b0;
    for (int s = 0; s < 3; s++) step(e);
    value_in = 16'h2222; dp_in = 4'b0001; load = 1'b1;
    step(e);
    load = 1'b0;
    for (int s = 0; s < 24; s++) begin
      step(e);
      checks++;
      if (an !== e.an || seg !== e.seg || dp !== e.dp || frame_done !== e.fd) begin
        errors++;
        $display("FAIL double_load got %b/%b/%b want %b/%b/%b", an, seg, dp, e.an, e.seg, e.dp);
      end
      if (an == 4'b1110) begin d0_seg = seg; d0_dp = dp; end
    end
    checks++;
    if (d0_seg !== 7'b0010010 || d0_dp !== 1'b0) begin
      errors++;
      $display("FAIL double_load_d0 seg=%b dp=%b want 0010010/0", d0_seg, d0_dp);
    end
  endtask

  task automatic test_blank();
    exp_t e;
    blank = 1'b1;
    for (int s = 0; s < 10; s++) begin
      step(e);
      checks++;
      if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || frame_done !== e.fd) begin
        errors++;
        $display("FAIL blank an=%b seg=%b dp=%b want 1111/1111111/1", an, seg, dp);
      end
    end
    blank = 1'b0;
    for (int s = 0; s < 16; s++) begin
      step(e);
      checks++;
      if (an !== e.an || seg !== e.seg || dp !== e.dp || frame_done !== e.fd) begin
        errors++;
        $display("FAIL after_blank got %b/%b/%b/%b want %b/%b/%b/%b",
                 an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   guard = 0;
    while (!(m_idx == 0 && m_cnt == 1) && guard < 32) begin step(e); guard++; end
    value_in = 16'h9999; dp_in = 4'b1111; load = 1'b1;
    step(e);
    load = 1'b0;
    guard = 0;
    while (m_idx != 2 && guard < 32) begin step(e); guard++; end
    step(e);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset an=%b seg=%b dp=%b fd=%b want 1111/1111111/1/0", an, seg, dp, frame_done);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int s = 0; s < 20; s++) begin
      step(e);
      checks++;
      if (an !== e.an || seg !== e.seg || dp !== e.dp || frame_done !== e.fd ||
          (s == 0 && an !== 4'b1110) || (an !== 4'hF && seg !== 7'b0000001)) begin
        errors++;
        $display("FAIL reset_restart step %0d got %b/%b/%b want %b/%b/%b",
                 s, an, seg, dp, e.an, e.seg, e.dp);
      end
    end
  endtask

  task automatic test_lz();
    exp_t e;
    int   lit [4];
    logic [6:0] d1_seg = 7'h7F;
    value_in = 16'h0050; dp_in = 4'b0000; load = 1'b1;
    step(e);
    load = 1'b0;
    for (int s = 0; s < 20; s++) step(e);
    for (int i = 0; i < 4; i++) lit[i] = 0;
    for (int s = 0; s < 16; s++) begin
      step(e);
      checks++;
      if (an !== e.an || seg !== e.seg || dp !== e.dp) begin
        errors++;
        $display("FAIL lz_scan got %b/%b/%b want %b/%b/%b", an, seg, dp, e.an, e.seg, e.dp);
      end
      for (int i = 0; i < 4; i++) if (an == ~(4'b0001 << i)) lit[i]++;
      if (an == 4'b1101) d1_seg = seg;
    end
    checks++;
`ifdef SSEG_LZ_BLANK_EN
    if (lit[0] != 4 || lit[1] != 4 || lit[2] != 0 || lit[3] != 0 || d1_seg !== 7'b0100100) begin
      errors++;
      $display("FAIL lz_lit counts %0d %0d %0d %0d d1=%b want 4 4 0 0 d1=0100100",
               lit[0], lit[1], lit[2], lit[3], d1_seg);
    end
`else
    if (lit[0] != 4 || lit[1] != 4 || lit[2] != 4 || lit[3] != 4 || d1_seg !== 7'b0100100) begin
      errors++;
      $display("FAIL lz_lit counts %0d %0d %0d %0d d1=%b want 4 4 4 4 d1=0100100",
               lit[0], lit[1], lit[2], lit[3], d1_seg);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_scan_idle();
    test_load_midframe();
    test_load_wrap();
    test_blank();
    test_reset_mid();
    test_lz();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
